// File: rtl/airi5c_hasti_dma.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : airi5c_hasti_dma
// Brief   : single-channel AHB-lite (HASTI) word-copy engine, one
//           non-overlapped SINGLE transfer at a time (read, then write)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module airi5c_hasti_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          haddr,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [2:0]           hburst,
  output logic                 hmastlock,
  output logic [3:0]           hprot,
  output logic [1:0]           htrans,
  output logic [31:0]          hwdata,
  input  logic [31:0]          hrdata,
  input  logic                 hready,
  input  logic                 hresp
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_RD_A = 3'd1;
  localparam logic [2:0] c_ST_RD_D = 3'd2;
  localparam logic [2:0] c_ST_WR_A = 3'd3;
  localparam logic [2:0] c_ST_WR_D = 3'd4;
  localparam logic [2:0] c_ST_FIN  = 3'd5;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [31:0]          r_data;
  logic                 r_error;
  logic                 w_misalign;

  assign w_misalign = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  assign hsize     = 3'd2;
  assign hburst    = 3'd0;
  assign hmastlock = 1'b0;
  assign hprot     = 4'b0011;
  assign hwdata    = r_data;
  assign error     = r_error;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_ST_IDLE: begin
        if (start && !w_misalign)
          w_state_nxt = (len_words == '0) ? c_ST_FIN : c_ST_RD_A;
      end
      c_ST_RD_A: if (hready) w_state_nxt = c_ST_RD_D;
      c_ST_RD_D: if (hready) w_state_nxt = hresp ? c_ST_IDLE : c_ST_WR_A;
      c_ST_WR_A: if (hready) w_state_nxt = c_ST_WR_D;
      c_ST_WR_D: begin
        if (hready) begin
          if (hresp)                           w_state_nxt = c_ST_IDLE;
          else if (r_rem == LEN_WIDTH'(1))     w_state_nxt = c_ST_FIN;
          else                                 w_state_nxt = c_ST_RD_A;
        end
      end
      c_ST_FIN:  w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs decode purely from state so address-phase signals stay frozen across waits
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    htrans = c_HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = 32'd0;
    unique case (r_state)
      c_ST_RD_A: begin
        busy   = 1'b1;
        htrans = c_HTRANS_NONSEQ;
        haddr  = r_src;
      end
      c_ST_RD_D: busy = 1'b1;
      c_ST_WR_A: begin
        busy   = 1'b1;
        htrans = c_HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = r_dst;
      end
      c_ST_WR_D: busy = 1'b1;
      c_ST_FIN:  done = 1'b1;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src   <= 32'd0;
      r_dst   <= 32'd0;
      r_rem   <= '0;
      r_data  <= 32'd0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_rem   <= len_words;
            r_error <= w_misalign;
          end
        end
        c_ST_RD_D: begin
          if (hready) begin
            if (hresp) r_error <= 1'b1;
            else       r_data  <= hrdata;
          end
        end
        c_ST_WR_D: begin
          if (hready) begin
            if (hresp) begin
              r_error <= 1'b1;
            end else begin
              r_src <= r_src + 32'd4;
              r_dst <= r_dst + 32'd4;
              r_rem <= r_rem - LEN_WIDTH'(1);
            end
          end
        end
        default: begin
          r_error <= r_error;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
